// File: rtl/alu_operand_stage.sv
// Operand/issue stage feeding sixty_four_bit_alu: register file, RV64 decode, registered ALU bundle.
// Optional macro ALU_OPERAND_BYPASS_EN forwards a same-cycle writeback into the captured operands.
module alu_operand_stage #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic            a_invert,
    output logic            b_invert,
    output logic [1:0]      operation,
    output logic            carry_in,
    output logic [4:0]      rd,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;

    localparam logic [1:0] BSEL_ZERO  = 2'b00;
    localparam logic [1:0] BSEL_RS2   = 2'b01;
    localparam logic [1:0] BSEL_IMM_I = 2'b10;
    localparam logic [1:0] BSEL_IMM_S = 2'b11;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] rd_idx;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign rd_idx  = instr[11:7];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

    logic            dec_legal;
    logic [1:0]      dec_op;
    logic            dec_b_inv;
    logic            dec_cin;
    logic [1:0]      dec_bsel;
    logic            dec_use_rs1;
    logic            dec_has_rd;

    // SUB and BEQ share the two's-complement controls: invert b and inject a carry.
    always_comb begin
        dec_legal   = 1'b0;
        dec_op      = ALU_AND;
        dec_b_inv   = 1'b0;
        dec_cin     = 1'b0;
        dec_bsel    = BSEL_ZERO;
        dec_use_rs1 = 1'b0;
        dec_has_rd  = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_ADD;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_ADD;
                    dec_b_inv = 1'b1;
                    dec_cin   = 1'b1;
                end else if (funct7 == F7_BASE && funct3 == 3'b111) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_AND;
                end else if (funct7 == F7_BASE && funct3 == 3'b110) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_OR;
                end
                if (dec_legal) begin
                    dec_bsel    = BSEL_RS2;
                    dec_use_rs1 = 1'b1;
                    dec_has_rd  = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_legal   = 1'b1;
                    dec_op      = ALU_ADD;
                    dec_bsel    = BSEL_IMM_I;
                    dec_use_rs1 = 1'b1;
                    dec_has_rd  = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b011) begin
                    dec_legal   = 1'b1;
                    dec_op      = ALU_ADD;
                    dec_bsel    = BSEL_IMM_I;
                    dec_use_rs1 = 1'b1;
                    dec_has_rd  = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b011) begin
                    dec_legal   = 1'b1;
                    dec_op      = ALU_ADD;
                    dec_bsel    = BSEL_IMM_S;
                    dec_use_rs1 = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b000) begin
                    dec_legal   = 1'b1;
                    dec_op      = ALU_ADD;
                    dec_b_inv   = 1'b1;
                    dec_cin     = 1'b1;
                    dec_bsel    = BSEL_RS2;
                    dec_use_rs1 = 1'b1;
                end
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    logic [XLEN-1:0] regs [NREGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    logic [XLEN-1:0] rf_rs1;
    logic [XLEN-1:0] rf_rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign rf_rs1 = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
    assign rf_rs2 = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];

`ifdef ALU_OPERAND_BYPASS_EN
    logic fwd_rs1;
    logic fwd_rs2;

    assign fwd_rs1 = wb_en && (wb_rd == rs1_idx) && (rs1_idx != 5'd0);
    assign fwd_rs2 = wb_en && (wb_rd == rs2_idx) && (rs2_idx != 5'd0);
    assign rs1_val = fwd_rs1 ? wb_data : rf_rs1;
    assign rs2_val = fwd_rs2 ? wb_data : rf_rs2;
`else
    // Without forwarding the upstream scheduler must keep a writeback off the registers it reads.
    assign rs1_val = rf_rs1;
    assign rs2_val = rf_rs2;
`endif

    logic [XLEN-1:0] next_a;
    logic [XLEN-1:0] next_b;

    always_comb begin
        next_a = dec_use_rs1 ? rs1_val : '0;
        case (dec_bsel)
            BSEL_RS2:   next_b = rs2_val;
            BSEL_IMM_I: next_b = imm_i;
            BSEL_IMM_S: next_b = imm_s;
            default:    next_b = '0;
        endcase
    end

    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // The bundle only changes on acceptance, so a stalled bundle is a stable snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            a_invert  <= 1'b0;
            b_invert  <= 1'b0;
            operation <= 2'b00;
            carry_in  <= 1'b0;
            rd        <= 5'd0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            a         <= next_a;
            b         <= next_b;
            a_invert  <= 1'b0;
            b_invert  <= dec_b_inv;
            operation <= dec_op;
            carry_in  <= dec_cin;
            rd        <= dec_has_rd ? rd_idx : 5'd0;
            illegal   <= !dec_legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage; honours ALU_OPERAND_BYPASS_EN when defined.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        a_invert;
    logic        b_invert;
    logic [1:0]  operation;
    logic        carry_in;
    logic [4:0]  rd;
    logic        illegal;

    int checkCount;
    int errorCount;

    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_SUB    = 32'h402081B3;
    localparam logic [31:0] I_AND    = 32'h0020F1B3;
    localparam logic [31:0] I_OR     = 32'h0020E1B3;
    localparam logic [31:0] I_ADDI   = 32'hFFF08293;
    localparam logic [31:0] I_SD     = 32'h0020B423;
    localparam logic [31:0] I_ADDX0  = 32'h00100233;
    localparam logic [31:0] I_BEQ    = 32'h00208063;
    localparam logic [31:0] I_LD     = 32'h01013303;
    localparam logic [31:0] I_ILLEG  = 32'h002081FF;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

    alu_operand_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .a_invert  (a_invert),
        .b_invert  (b_invert),
        .operation (operation),
        .carry_in  (carry_in),
        .rd        (rd),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs after the falling edge, then lands just past the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy,
                                 input logic we, input logic [4:0] wr, input logic [63:0] wd);
        @(negedge clk);
        in_valid  = v;
        instr     = ins;
        out_ready = rdy;
        wb_en     = we;
        wb_rd     = wr;
        wb_data   = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBundle(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                               input logic [1:0] eop, input logic einv, input logic [4:0] erd);
        checkOutput({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        checkOutput({tag, ".a"}, a, ea);
        checkOutput({tag, ".b"}, b, eb);
        checkOutput({tag, ".op"}, {62'd0, operation}, {62'd0, eop});
        checkOutput({tag, ".binv"}, {63'd0, b_invert}, {63'd0, einv});
        checkOutput({tag, ".cin"}, {63'd0, carry_in}, {63'd0, einv});
        checkOutput({tag, ".ainv"}, {63'd0, a_invert}, 64'd0);
        checkOutput({tag, ".rd"}, {59'd0, rd}, {59'd0, erd});
    endtask

    logic [63:0] bypassExpect;

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        instr      = 32'd0;
        out_ready  = 1'b1;
        wb_en      = 1'b0;
        wb_rd      = 5'd0;
        wb_data    = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset.ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset.a", a, 64'd0);
        checkOutput("reset.rd", {59'd0, rd}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 64'd1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, ONES);
        checkOutput("idle.valid", {63'd0, out_valid}, 64'd0);

        applyStimulus(1'b1, I_ADD, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("add", 64'd1, ONES, 2'b10, 1'b0, 5'd3);
        checkOutput("add.illegal", {63'd0, illegal}, 64'd0);
        applyStimulus(1'b1, I_SUB, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("sub", 64'd1, ONES, 2'b10, 1'b1, 5'd3);
        applyStimulus(1'b1, I_AND, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("and", 64'd1, ONES, 2'b00, 1'b0, 5'd3);
        applyStimulus(1'b1, I_OR, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("or", 64'd1, ONES, 2'b01, 1'b0, 5'd3);
        applyStimulus(1'b1, I_ADDI, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("addi", 64'd1, ONES, 2'b10, 1'b0, 5'd5);
        applyStimulus(1'b1, I_SD, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("sd", 64'd1, 64'd8, 2'b10, 1'b0, 5'd0);

        // Stall three cycles on the sd bundle while x1 is rewritten underneath it.
        applyStimulus(1'b1, I_ADD, 1'b0, 1'b1, 5'd1, 64'd7);
        checkOutput("stall0.ready", {63'd0, in_ready}, 64'd0);
        checkBundle("stall0", 64'd1, 64'd8, 2'b10, 1'b0, 5'd0);
        for (int i = 1; i < 3; i++) begin
            applyStimulus(1'b1, I_ADD, 1'b0, 1'b0, 5'd0, 64'd0);
            checkOutput("stall.ready", {63'd0, in_ready}, 64'd0);
            checkBundle("stall", 64'd1, 64'd8, 2'b10, 1'b0, 5'd0);
        end
        applyStimulus(1'b1, I_ADD, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("release", 64'd7, ONES, 2'b10, 1'b0, 5'd3);

`ifdef ALU_OPERAND_BYPASS_EN
        bypassExpect = 64'h55;
`else
        bypassExpect = 64'd7;
`endif
        applyStimulus(1'b1, I_ADD, 1'b1, 1'b1, 5'd1, 64'h55);
        checkBundle("wbsame", bypassExpect, ONES, 2'b10, 1'b0, 5'd3);

        applyStimulus(1'b1, I_ADDX0, 1'b1, 1'b1, 5'd0, 64'h99);
        checkBundle("x0", 64'd0, 64'h55, 2'b10, 1'b0, 5'd4);
        applyStimulus(1'b1, I_ADDX0, 1'b1, 1'b0, 5'd0, 64'd0);
        checkOutput("x0again.a", a, 64'd0);

        applyStimulus(1'b1, I_BEQ, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("beq", 64'h55, ONES, 2'b10, 1'b1, 5'd0);
        applyStimulus(1'b1, I_LD, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("ld", ONES, 64'd16, 2'b10, 1'b0, 5'd6);

        applyStimulus(1'b1, I_ILLEG, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("illegal", 64'd0, 64'd0, 2'b00, 1'b0, 5'd0);
        checkOutput("illegal.flag", {63'd0, illegal}, 64'd1);

        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 64'd0);
        checkOutput("drain.valid", {63'd0, out_valid}, 64'd0);

        applyStimulus(1'b1, I_ADDI, 1'b1, 1'b0, 5'd0, 64'd0);
        checkOutput("prereset.valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset.valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset.b", b, 64'd0);
        checkOutput("midreset.ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, I_ADD, 1'b1, 1'b0, 5'd0, 64'd0);
        checkBundle("postreset", 64'd0, 64'd0, 2'b10, 1'b0, 5'd3);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
